seq_bin_bcd_converter: RTL and testbench

Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock. It replaces the fixed 8-bit combinational converter in wide display and readout paths such as 16-bit counters and 7-segment drivers. Valid/ready handshakes on input and output let it sit between a counter/register source and a display multiplexer under backpressure.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_adjust.sv | 17 +
 rtl/seq_bin_bcd_converter.sv | 114 +++++++++++
 tb/tb_seq_bin_bcd_converter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// min_digits() sizes the decimal output needed for a given binary width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  // Number of decimal digits needed to represent 2^width - 1 (width 1..32).
  function automatic int min_digits(input int width);
    longint unsigned v;
    int n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n++;
        v = v / 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADD3_THRESH) begin
      digit_out = digit_in + ADD3_VAL;
    end
  end

endmodule

// File: rtl/seq_bin_bcd_converter.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one operand bit per
// clock, with valid/ready handshakes on both sides.
module seq_bin_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  generate
    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
      $error("seq_bin_bcd_converter: BIN_W=%0d outside 1..32", BIN_W);
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $error("seq_bin_bcd_converter: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end
  endgenerate

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   operand_q, operand_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   accept;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (bcd_q[4*gi +: 4]),
      .digit_out (adj[4*gi +: 4])
    );
  end

  // Correction happens before the shift; the operand MSB moves into bcd[0].
  assign shifted = {adj, operand_q} << 1;
  assign accept  = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (count_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; in_ready is masked by rst so nothing is accepted during reset.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT) || (state_q == DONE);
    bcd       = bcd_q;
  end

  // Datapath next values
  always_comb begin
    operand_d = operand_q;
    bcd_d     = bcd_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          operand_d = bin;
          bcd_d     = '0;
          count_d   = CNT_W'(BIN_W);
        end
      end
      SHIFT: begin
        bcd_d     = shifted[BCD_W+BIN_W-1:BIN_W];
        operand_d = shifted[BIN_W-1:0];
        count_d   = count_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q <= '0;
      bcd_q     <= '0;
      count_q   <= '0;
    end else begin
      operand_q <= operand_d;
      bcd_q     <= bcd_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_seq_bin_bcd_converter.sv
// Directed bench for the sequential binary-to-BCD converter: a 16-bit/5-digit
// instance for handshake/timing cases and an 8-bit/3-digit instance swept 0..255.
module tb_seq_bin_bcd_converter;

  logic        clk;
  logic        rst;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] bin16;
  logic [19:0] bcd16;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;

  int total = 0;
  int bad   = 0;

  logic [31:0] q16[$];
  logic [31:0] q8[$];

  seq_bin_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .bin       (bin16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .bcd       (bcd16),
    .busy      (busy16)
  );

  seq_bin_bcd_converter #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .bin       (bin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .bcd       (bcd8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digit extraction, independent of the shift-and-add algorithm.
  function automatic logic [31:0] to_bcd(input int unsigned v, input int nd);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop16(input string tag);
    logic [31:0] e;
    if (q16.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, bcd16);
    end else begin
      e = q16.pop_front();
      check(tag, {12'h0, bcd16}, e);
      $display("txn16 %s bcd=%05h exp=%05h", tag, bcd16, e[19:0]);
    end
  endtask

  // Handshake one value into dut16 and wait for its result; returns the latency
  // and whether in_ready stayed low during the conversion. out_ready stays low.
  task automatic start16(input logic [15:0] v, output int lat, output bit rdy_seen);
    in_valid16 = 1'b1;
    bin16      = v;
    tick();
    q16.push_back(to_bcd(v, 5));
    in_valid16 = 1'b0;
    bin16      = 16'hFFFF;
    lat        = 0;
    rdy_seen   = 1'b0;
    while (!out_valid16 && lat < 40) begin
      if (in_ready16) rdy_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic release16(input string tag);
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid16), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready16), 32'd1);
  endtask

  task automatic convert16(input string tag, input logic [15:0] v);
    int lat;
    bit rdy;
    start16(v, lat, rdy);
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_in_ready_low"}, 32'(rdy), 32'd0);
    sb_pop16(tag);
    release16(tag);
  endtask

  initial begin
    int lat;
    bit rdy;
    int n;
    int got;
    int idx;
    int times[3];
    logic [15:0] svals[3];
    logic [31:0] e;

    rst = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b0; bin16 = '0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; bin8  = '0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_bcd", 32'(bcd16), 32'd0);
    check("rst_in_ready", 32'(in_ready16), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready16), 32'd1);

    // Basic conversion and boundaries
    convert16("bin255", 16'd255);
    convert16("bin0", 16'd0);
    convert16("bin65535", 16'd65535);
    convert16("bin9999", 16'd9999);

    // Backpressure with an ignored in_valid during DONE
    start16(16'd1234, lat, rdy);
    check("bp_latency", 32'(lat), 32'd16);
    e = to_bcd(1234, 5);
    in_valid16 = 1'b1;
    bin16      = 16'd999;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid16), 32'd1);
      check("bp_hold_bcd", 32'(bcd16), e);
      check("bp_in_ready", 32'(in_ready16), 32'd0);
    end
    in_valid16 = 1'b0;
    sb_pop16("bin1234");
    release16("bp");
    tick();
    check("bp_idle_hold_bcd", 32'(bcd16), e);
    check("bp_no_extra_valid", 32'(out_valid16), 32'd0);

    // Reset in the middle of a conversion
    in_valid16 = 1'b1;
    bin16      = 16'd40000;
    tick();
    in_valid16 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_busy", 32'(busy16), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_bcd", 32'(bcd16), 32'd0);
    check("mid_rst_valid", 32'(out_valid16), 32'd0);
    check("mid_rst_busy", 32'(busy16), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready16), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 32'(in_ready16), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid16) n++;
      tick();
    end
    check("mid_no_valid", 32'(n), 32'd0);
    $display("txn16 mid_reset bin=40000 discarded");
    convert16("bin9", 16'd9);

    // Streaming with in_valid/out_ready held high
    svals[0] = 16'd1; svals[1] = 16'd10; svals[2] = 16'd100;
    idx = 0;
    got = 0;
    in_valid16  = 1'b1;
    bin16       = svals[0];
    out_ready16 = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      if (out_valid16) begin
        times[got] = cyc;
        got++;
        sb_pop16("stream");
      end
      if (in_valid16 && in_ready16) begin
        q16.push_back(to_bcd(32'(svals[idx]), 5));
        idx++;
      end
      tick();
      if (idx < 3) bin16 = svals[idx];
      else in_valid16 = 1'b0;
    end
    in_valid16  = 1'b0;
    out_ready16 = 1'b0;
    check("stream_count", 32'(got), 32'd3);
    if (got == 3) begin
      check("stream_gap01", 32'(times[1] - times[0]), 32'd18);
      check("stream_gap12", 32'(times[2] - times[1]), 32'd18);
    end

    // Exhaustive sweep of the 8-bit instance
    out_ready8 = 1'b1;
    for (int v = 0; v < 256; v++) begin
      in_valid8 = 1'b1;
      bin8      = 8'(v);
      tick();
      q8.push_back(to_bcd(v, 3));
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 20) begin
        tick();
        n++;
      end
      if (n != 8) check("sw8_latency", 32'(n), 32'd8);
      if (q8.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sw8 observed=%0h expected=<empty scoreboard>", bcd8);
      end else begin
        e = q8.pop_front();
        check("sw8", {20'h0, bcd8}, e);
        $display("txn8 bin=%0d bcd=%03h exp=%03h", v, bcd8, e[11:0]);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
